if_prefetch_queue: RTL

- Parametrised fetch front-end that replaces the single-entry PC-to-cache fetch path.
- Runs ahead of the consumer, fetching sequential instructions into a DEPTH-entry queue over the level-request/ready-pulse instruction memory handshake.
- Flushes on redirect (jump, branch, trap, xRET) and reports instruction-address-misaligned exceptions.
- Sits between the instruction cache/memory port and decode of the pipelined datapath.

---
 rtl/arvi_fetch_pkg.sv | 19 +
 rtl/sync_fifo.sv | 68 ++++++
 rtl/if_prefetch_queue.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/arvi_fetch_pkg.sv
// rtl/arvi_fetch_pkg.sv - shared types and constants for the instruction prefetch front-end
package arvi_fetch_pkg;

    localparam int unsigned FETCH_XLEN = 32;
    localparam logic [31:0] RV_NOP     = 32'h0000_0013;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2,
        EXC   = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - power-of-two synchronous FIFO with flush, holding packed fetch entries
module sync_fifo
    import arvi_fetch_pkg::*;
#(
    parameter int unsigned WIDTH = $bits(fetch_entry_t),
    parameter int unsigned DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    input  logic                   i_flush,
    output logic [WIDTH-1:0]       o_data,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (i_push) begin
                mem_d[wr_ptr_q] = i_data;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (i_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (i_push && !i_pop) begin
                count_d = count_q + (AW+1)'(1);
            end else if (!i_push && i_pop) begin
                count_d = count_q - (AW+1)'(1);
            end
        end
    end

    // Storage is not reset; the count gates every read of it.
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
        if (!i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign o_data  = mem_q[rd_ptr_q];
    assign o_count = count_q;

endmodule

// File: rtl/if_prefetch_queue.sv
// rtl/if_prefetch_queue.sv - sequential instruction prefetch queue with redirect flush and misaligned-fetch reporting
// Optional performance counters are enabled with ARVI_PREFETCH_PERF_EN.
module if_prefetch_queue
    import arvi_fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] PC_RESET = 32'h0000_0000
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic            o_mem_req,
    output logic [XLEN-1:0] o_mem_addr,
    input  logic            i_mem_ready,
    input  logic [XLEN-1:0] i_mem_data,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_valid,
    output logic [XLEN-1:0] o_instr,
    output logic [XLEN-1:0] o_pc,
    output logic            o_ex_inst_addr,
    input  logic            i_ready
`ifdef ARVI_PREFETCH_PERF_EN
    ,
    output logic [XLEN-1:0] o_perf_starve,
    output logic [XLEN-1:0] o_perf_flush
`endif
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fetch_state_t      state_q, state_d;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]   req_addr_q, req_addr_d;
    logic              exc_pend_q, exc_pend_d;
    logic [CW-1:0]     count;
    logic [2*XLEN-1:0] head;
    logic              in_flight, aligned, has_entry, exc_head, push, pop;

    assign in_flight = (state_q == WAIT) || (state_q == DRAIN);
    assign aligned   = (i_redirect_pc[1:0] == 2'b00);
    assign has_entry = (count != '0);
    assign exc_head  = (state_q == EXC) && exc_pend_q;
    assign push      = (state_q == WAIT) && i_mem_ready && !i_redirect;
    assign pop       = has_entry && i_ready && !i_redirect;

    sync_fifo #(
        .WIDTH (2*XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_data  ({req_addr_q, i_mem_data}),
        .i_pop   (pop),
        .i_flush (i_redirect),
        .o_data  (head),
        .o_count (count)
    );

    // An aligned redirect with nothing outstanding issues its fetch directly,
    // so the new request is visible the cycle after the redirect.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        exc_pend_d = exc_pend_q;
        if (i_redirect) begin
            fetch_pc_d = i_redirect_pc;
            exc_pend_d = !aligned;
            if (in_flight && !i_mem_ready) begin
                state_d = DRAIN;
            end else if (!aligned) begin
                state_d = EXC;
            end else begin
                state_d    = WAIT;
                req_addr_d = i_redirect_pc;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (count < CW'(DEPTH)) begin
                        state_d    = WAIT;
                        req_addr_d = fetch_pc_q;
                    end
                end
                WAIT: begin
                    if (i_mem_ready) begin
                        state_d    = IDLE;
                        fetch_pc_d = req_addr_q + XLEN'(4);
                    end
                end
                DRAIN: begin
                    if (i_mem_ready) begin
                        state_d = exc_pend_q ? EXC : IDLE;
                    end
                end
                EXC: begin
                    if (exc_head && i_ready) begin
                        exc_pend_d = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= PC_RESET;
            req_addr_q <= PC_RESET;
            exc_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            exc_pend_q <= exc_pend_d;
        end
    end

    assign o_mem_req  = in_flight;
    assign o_mem_addr = req_addr_q;

    // In EXC the queue is empty and fetch_pc holds the faulting target.
    always_comb begin
        o_valid        = has_entry || exc_head;
        o_ex_inst_addr = exc_head;
        o_pc           = '0;
        o_instr        = '0;
        if (exc_head) begin
            o_pc    = fetch_pc_q;
            o_instr = XLEN'(RV_NOP);
        end else if (has_entry) begin
            o_pc    = head[2*XLEN-1:XLEN];
            o_instr = head[XLEN-1:0];
        end
    end

`ifdef ARVI_PREFETCH_PERF_EN
    logic [XLEN-1:0] starve_q, starve_d;
    logic [XLEN-1:0] flush_q, flush_d;

    always_comb begin
        starve_d = starve_q;
        flush_d  = flush_q;
        if (!o_valid && i_ready && (starve_q != '1)) begin
            starve_d = starve_q + XLEN'(1);
        end
        if (i_redirect && (has_entry || (state_q == WAIT)) && (flush_q != '1)) begin
            flush_d = flush_q + XLEN'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            starve_q <= '0;
            flush_q  <= '0;
        end else begin
            starve_q <= starve_d;
            flush_q  <= flush_d;
        end
    end

    assign o_perf_starve = starve_q;
    assign o_perf_flush  = flush_q;
`endif

endmodule
